// File: rtl/array_xform_pkg.sv
// Shared types and defaults for the array transform arbiter: operation codes,
// controller state encoding and default geometry.
package array_xform_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_MOD5 = 2'd0,
    OP_DIV2 = 2'd1,
    OP_SHR2 = 2'd2,
    OP_CLR  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/array_xform_arbiter_if.sv
// One requester's handshake with the arbiter: request, operation, target entry
// and operand, plus the grant and completion pulses.
interface array_xform_arbiter_if
  import array_xform_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = 2
);

  logic          req;
  op_t           op;
  logic [AW-1:0] idx;
  logic [DW-1:0] data;
  logic          gnt;
  logic          done;

  modport master (
    output req, op, idx, data,
    input  gnt, done
  );

  modport slave (
    input  req, op, idx, data,
    output gnt, done
  );

endinterface

// File: rtl/array_xform_alu.sv
// Combinational transform unit: applies one of the four fixed unsigned
// transforms to an operand.
module array_xform_alu
  import array_xform_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  op_t           op,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] result
);

  always_comb begin
    // NOTE: a default assignment on entry keeps every path driven, so no latch is inferred.
    result = '0;
    case (op)
      OP_MOD5: result = data % DW'(5);
      OP_DIV2: result = data / DW'(2);
      OP_SHR2: result = data >> 2;
      OP_CLR:  result = '0;
    endcase
  end

endmodule

// File: rtl/array_xform_arbiter.sv
// Round-robin two-requester controller that serialises transform-and-write
// operations into a small register array with a registered read port.
module array_xform_arbiter
  import array_xform_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  array_xform_arbiter_if.slave  a,
  array_xform_arbiter_if.slave  b,
  output logic [DW-1:0]         done_data,
  input  logic [AW-1:0]         rd_idx,
  output logic [DW-1:0]         rd_data,
  output logic                  busy
);

  state_t        state, state_next;
  logic          last_b;
  logic          a_hold, b_hold;
  logic          a_eff, b_eff, pick_b, start;
  logic          a_gnt_next, b_gnt_next, a_done_next, b_done_next, busy_next;
  op_t           op_q;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] data_q, result_q, alu_result;
  logic          owner_b;
  logic [DW-1:0] mem [DEPTH];

  // A granted request stays masked until its req is seen low, so a requester
  // that is slow to drop req does not get served twice.
  assign a_eff  = a.req & ~a_hold;
  assign b_eff  = b.req & ~b_hold;
  assign start  = a_eff | b_eff;
  assign pick_b = b_eff & (~a_eff | ~last_b);

  array_xform_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .data   (data_q),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_gnt_next  = (state == IDLE) && start && !pick_b;
    b_gnt_next  = (state == IDLE) && pick_b;
    a_done_next = (state == WRITE) && !owner_b;
    b_done_next = (state == WRITE) && owner_b;
    busy_next   = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a.gnt     <= 1'b0;
      b.gnt     <= 1'b0;
      a.done    <= 1'b0;
      b.done    <= 1'b0;
      busy      <= 1'b0;
      last_b    <= 1'b1;
      a_hold    <= 1'b0;
      b_hold    <= 1'b0;
      op_q      <= OP_MOD5;
      idx_q     <= '0;
      data_q    <= '0;
      owner_b   <= 1'b0;
      result_q  <= '0;
      done_data <= '0;
    end else begin
      a.gnt  <= a_gnt_next;
      b.gnt  <= b_gnt_next;
      a.done <= a_done_next;
      b.done <= b_done_next;
      busy   <= busy_next;
      a_hold <= a_gnt_next | (a_hold & a.req);
      b_hold <= b_gnt_next | (b_hold & b.req);
      if (a_gnt_next || b_gnt_next) begin
        last_b  <= b_gnt_next;
        owner_b <= b_gnt_next;
        op_q    <= b_gnt_next ? b.op   : a.op;
        idx_q   <= b_gnt_next ? b.idx  : a.idx;
        data_q  <= b_gnt_next ? b.data : a.data;
      end
      if (state == EXEC)  result_q  <= alu_result;
      if (state == WRITE) done_data <= result_q;
    end
  end

  // Read and write share the edge; the read sees the pre-write entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the array is reset explicitly because a reset must leave every entry at zero.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_idx];
      if (state == WRITE) mem[idx_q] <= result_q;
    end
  end

endmodule
